// File: rtl/conv_pkg.sv
// conv_pkg: shared defaults, FSM state type and 3x3 window tap indexing for conv_window_gen.
//   DEF_IMG_W/DEF_IMG_H/DEF_PIX_W : default image geometry and pixel width
//   conv_state_t                  : IDLE / STREAM
//   WIN_*, tap()                  : window slice k = row*3 + col, row 0 = top, col 0 = left
package conv_pkg;

    localparam int DEF_IMG_W = 120;
    localparam int DEF_IMG_H = 120;
    localparam int DEF_PIX_W = 3;

    localparam int WIN_COLS = 3;
    localparam int WIN_ROWS = 3;
    localparam int WIN_TAPS = WIN_COLS * WIN_ROWS;
    localparam int WIN_CTR  = 4;

    typedef enum logic {
        IDLE,
        STREAM
    } conv_state_t;

    function automatic int tap(input int col, input int row);
        return row * WIN_COLS + col;
    endfunction

endpackage

// File: rtl/conv_line_buf.sv
// conv_line_buf: IMG_W-deep delay line; one read-before-write access per cycle at addr.
//   clk  : clock
//   we   : write din at addr (dout shows the previous row's pixel at addr)
//   addr : column index
//   din  : pixel to store
//   dout : stored pixel at addr (combinational read, contents are not reset)
module conv_line_buf
    import conv_pkg::*;
#(
    parameter int DEPTH = DEF_IMG_W,
    parameter int W     = DEF_PIX_W,
    parameter int AW    = $clog2(DEF_IMG_W)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
    end

    assign dout = mem[addr];

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: streams a raster image and emits 3x3 windows for every interior pixel.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : one-cycle pulse, begins a frame when idle
//   pix_valid/pix_ready  : raster pixel input handshake, pixel on pix_din
//   win_valid/win_ready  : window output handshake; win_pix slice k = (win_x-1+k%3, win_y-1+k/3)
//   win_x, win_y         : window centre coordinates
//   busy                 : frame in progress
//   frame_done           : pulse on the handshake of the last window
//   win_stall_cnt        : (only with CONV_WIN_STALL_CNT_EN) saturating count of stalled output cycles
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int PIX_W = DEF_PIX_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      pix_valid,
    input  logic [PIX_W-1:0]          pix_din,
    output logic                      pix_ready,
    output logic                      win_valid,
    input  logic                      win_ready,
    output logic [WIN_TAPS*PIX_W-1:0] win_pix,
    output logic [7:0]                win_x,
    output logic [7:0]                win_y,
    output logic                      busy,
    output logic                      frame_done
`ifdef CONV_WIN_STALL_CNT_EN
    ,
    output logic [15:0]               win_stall_cnt
`endif
);

    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    conv_state_t state, state_nxt;
    logic [7:0] col, row;
    logic in_done, xfer, emit, start_acc, last_col;
    logic [PIX_W-1:0] lb1_q, lb2_q;
    logic [PIX_W-1:0] sr [2][WIN_ROWS];
    logic [PIX_W-1:0] ncol [WIN_ROWS];
    logic [WIN_TAPS*PIX_W-1:0] win_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        start_acc  = 1'b0;
        pix_ready  = 1'b0;
        busy       = 1'b0;
        frame_done = (state == STREAM) && win_valid && win_ready &&
                     (win_x == 8'(IMG_W - 2)) && (win_y == 8'(IMG_H - 2));
        case (state)
            IDLE: begin
                start_acc = start;
                state_nxt = start ? STREAM : IDLE;
            end
            STREAM: begin
                // accept a pixel only if the window register is free or draining this cycle
                pix_ready = (!win_valid || win_ready) && !in_done;
                busy      = !frame_done;
                state_nxt = frame_done ? IDLE : STREAM;
            end
        endcase
    end

    assign xfer     = pix_valid && pix_ready;
    assign last_col = (col == 8'(IMG_W - 1));
    // pixel (col,row) completes the window centred one up and one left; borders never qualify
    assign emit     = xfer && (col >= 8'd2) && (row >= 8'd2);

    conv_line_buf #(.DEPTH(IMG_W), .W(PIX_W), .AW(AW)) u_lb1 (
        .clk  (clk),
        .we   (xfer),
        .addr (col[AW-1:0]),
        .din  (pix_din),
        .dout (lb1_q)
    );

    conv_line_buf #(.DEPTH(IMG_W), .W(PIX_W), .AW(AW)) u_lb2 (
        .clk  (clk),
        .we   (xfer),
        .addr (col[AW-1:0]),
        .din  (lb1_q),
        .dout (lb2_q)
    );

    always_comb begin
        ncol[0] = lb2_q;
        ncol[1] = lb1_q;
        ncol[2] = pix_din;
        win_nxt = '0;
        for (int r = 0; r < WIN_ROWS; r++) begin
            win_nxt[tap(0, r)*PIX_W +: PIX_W] = sr[0][r];
            win_nxt[tap(1, r)*PIX_W +: PIX_W] = sr[1][r];
            win_nxt[tap(2, r)*PIX_W +: PIX_W] = ncol[r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            in_done   <= 1'b0;
            win_valid <= 1'b0;
            win_pix   <= '0;
            win_x     <= '0;
            win_y     <= '0;
            for (int r = 0; r < WIN_ROWS; r++) begin
                sr[0][r] <= '0;
                sr[1][r] <= '0;
            end
        end else begin
            if (start_acc) begin
                col     <= '0;
                row     <= '0;
                in_done <= 1'b0;
            end else if (xfer) begin
                col     <= last_col ? 8'd0 : col + 8'd1;
                row     <= last_col ? row + 8'd1 : row;
                in_done <= last_col && (row == 8'(IMG_H - 1));
                for (int r = 0; r < WIN_ROWS; r++) begin
                    sr[0][r] <= sr[1][r];
                    sr[1][r] <= ncol[r];
                end
            end
            if (emit) begin
                win_valid <= 1'b1;
                win_pix   <= win_nxt;
                win_x     <= col - 8'd1;
                win_y     <= row - 8'd1;
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

`ifdef CONV_WIN_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                            win_stall_cnt <= '0;
        else if (start_acc)                                    win_stall_cnt <= '0;
        else if (win_valid && !win_ready && ~&win_stall_cnt)   win_stall_cnt <= win_stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: randomized scoreboard bench for conv_window_gen (default and 5x5 builds).
module tb_conv_window_gen;

    localparam int W  = 120;
    localparam int H  = 120;
    localparam int P  = 3;
    localparam int N  = W * H;
    localparam int NW = (W - 2) * (H - 2);

    typedef struct {
        logic [9*P-1:0] pix;
        int             x;
        int             y;
    } win_t;

    logic clk = 0, rst_n = 0;
    logic start = 0, pix_valid = 0, win_ready = 0;
    logic [P-1:0] pix_din = '0;
    logic pix_ready, win_valid, busy, frame_done;
    logic [9*P-1:0] win_pix;
    logic [7:0] win_x, win_y;
    logic s_start = 0, s_pix_valid = 0, s_win_ready = 1;
    logic [P-1:0] s_pix_din = '0;
    logic s_pix_ready, s_win_valid, s_busy, s_frame_done;
    logic [9*P-1:0] s_win_pix;
    logic [7:0] s_win_x, s_win_y;
`ifdef CONV_WIN_STALL_CNT_EN
    logic [15:0] win_stall_cnt, s_win_stall_cnt;
`endif

    int n_tests = 0, n_fail = 0, n_win = 0;
    bit done_seen = 0;
    win_t sbq[$];
    logic [P-1:0] img [H][W];

    always #5 clk = ~clk;

    conv_window_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid), .pix_din(pix_din),
        .pix_ready(pix_ready), .win_valid(win_valid), .win_ready(win_ready), .win_pix(win_pix),
        .win_x(win_x), .win_y(win_y), .busy(busy), .frame_done(frame_done)
`ifdef CONV_WIN_STALL_CNT_EN
        , .win_stall_cnt(win_stall_cnt)
`endif
    );

    conv_window_gen #(.IMG_W(5), .IMG_H(5), .PIX_W(P)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .pix_valid(s_pix_valid), .pix_din(s_pix_din),
        .pix_ready(s_pix_ready), .win_valid(s_win_valid), .win_ready(s_win_ready), .win_pix(s_win_pix),
        .win_x(s_win_x), .win_y(s_win_y), .busy(s_busy), .frame_done(s_frame_done)
`ifdef CONV_WIN_STALL_CNT_EN
        , .win_stall_cnt(s_win_stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference: every interior centre in raster order, taps read straight from the image
    task automatic build_expect();
        win_t w;
        sbq.delete();
        for (int cy = 1; cy <= H - 2; cy++)
            for (int cx = 1; cx <= W - 2; cx++) begin
                for (int k = 0; k < 9; k++) w.pix[k*P +: P] = img[cy - 1 + k / 3][cx - 1 + k % 3];
                w.x = cx;
                w.y = cy;
                sbq.push_back(w);
            end
    endtask

    initial begin : monitor
        win_t e;
        forever begin
            @(negedge clk);
            #2;
            if (win_valid && win_ready) begin
                n_win++;
                if (sbq.size() == 0) chk("unexpected_window", 1, 0);
                else begin
                    e = sbq.pop_front();
                    chk("win_pix", win_pix, e.pix);
                    chk("win_x", win_x, e.x);
                    chk("win_y", win_y, e.y);
                    chk("frame_done", frame_done, sbq.size() == 0);
                end
                if (frame_done) done_seen = 1;
            end else begin
                chk("spurious_frame_done", frame_done, 0);
            end
        end
    end

    task automatic run_frame(input int pv_pct, input int wr_pct, input bit stall_first, input int abort_idx);
        int idx = 0, cyc = 0;
        bit stalled = 0, xf;
        logic [9*P-1:0] c_pix;
        logic [7:0] c_x, c_y;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) img[y][x] = P'($urandom);
        build_expect();
        done_seen = 0;
        n_win = 0;
        @(negedge clk);
        start = 0; pix_valid = 1; pix_din = img[0][0]; win_ready = 1;
        #1;
        chk("idle_pix_ready", pix_ready, 0);
        chk("idle_busy", busy, 0);
        @(negedge clk);
        #1;
        chk("idle_win_valid", win_valid, 0);
        @(negedge clk);
        start = 1; pix_valid = 0;
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        while (!done_seen && cyc < 60000) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            start = ($urandom_range(99) < 2);
            if (abort_idx >= 0 && idx >= abort_idx) begin
                start = 0; pix_valid = 0;
                #1 rst_n = 0;
                #1;
                chk("rst_win_valid", win_valid, 0);
                chk("rst_win_pix", win_pix, 0);
                chk("rst_win_x", win_x, 0);
                chk("rst_win_y", win_y, 0);
                chk("rst_busy", busy, 0);
                chk("rst_frame_done", frame_done, 0);
                chk("rst_pix_ready", pix_ready, 0);
`ifdef CONV_WIN_STALL_CNT_EN
                chk("rst_stall_cnt", win_stall_cnt, 0);
`endif
                sbq.delete();
                @(negedge clk);
                rst_n = 1;
                return;
            end
            if (stall_first && !stalled && win_valid) begin
                stalled = 1;
                c_pix = win_pix; c_x = win_x; c_y = win_y;
                for (int i = 0; i < 20; i++) begin
                    start = 0; win_ready = 0;
                    pix_valid = (idx < N);
                    pix_din = img[idx / W][idx % W];
                    #1;
                    chk("stall_pix_ready", pix_ready, 0);
                    chk("stall_win_valid", win_valid, 1);
                    chk("stall_win_pix", win_pix, c_pix);
                    chk("stall_win_x", win_x, c_x);
                    chk("stall_win_y", win_y, c_y);
                    @(negedge clk);
                end
`ifdef CONV_WIN_STALL_CNT_EN
                chk("stall_cnt", win_stall_cnt, 20);
`endif
            end
            pix_valid = (idx < N) && ($urandom_range(99) < pv_pct);
            pix_din = (idx < N) ? img[idx / W][idx % W] : P'($urandom);
            win_ready = ($urandom_range(99) < wr_pct);
            #1;
            xf = pix_valid && pix_ready;
            @(posedge clk);
            if (xf) idx++;
        end
        @(negedge clk);
        start = 0; pix_valid = 0;
        #1;
        chk("frame_done_seen", done_seen, 1);
        chk("window_count", n_win, NW);
        chk("scoreboard_empty", sbq.size(), 0);
        chk("busy_after_frame", busy, 0);
        chk("pix_ready_after_frame", pix_ready, 0);
    endtask

    task automatic run_small();
        win_t q5[$];
        win_t w, e;
        int sidx = 0, nw = 0;
        bit sdone = 0, xf;
        logic [9*P-1:0] first_pix;
        first_pix = {3'd4, 3'd3, 3'd2, 3'd3, 3'd2, 3'd1, 3'd2, 3'd1, 3'd0};
        for (int cy = 1; cy <= 3; cy++)
            for (int cx = 1; cx <= 3; cx++) begin
                for (int k = 0; k < 9; k++) w.pix[k*P +: P] = P'(((cx - 1 + k % 3) + (cy - 1 + k / 3)) % 8);
                w.x = cx;
                w.y = cy;
                q5.push_back(w);
            end
        @(negedge clk);
        s_start = 1; s_win_ready = 1;
        @(negedge clk);
        s_start = 0;
        for (int cyc = 0; cyc < 200 && !sdone; cyc++) begin
            if (cyc > 0) @(negedge clk);
            s_pix_valid = (sidx < 25);
            s_pix_din = P'(((sidx % 5) + (sidx / 5)) % 8);
            #2;
            if (s_win_valid) begin
                nw++;
                if (q5.size() == 0) chk("small_unexpected_window", 1, 0);
                else begin
                    e = q5.pop_front();
                    if (nw == 1) begin
                        chk("small_first_pix", s_win_pix, first_pix);
                        chk("small_first_x", s_win_x, 1);
                        chk("small_first_y", s_win_y, 1);
                    end
                    chk("small_win_pix", s_win_pix, e.pix);
                    chk("small_win_x", s_win_x, e.x);
                    chk("small_win_y", s_win_y, e.y);
                    chk("small_frame_done", s_frame_done, q5.size() == 0);
                end
                if (s_frame_done) begin
                    sdone = 1;
                    chk("small_last_x", s_win_x, 3);
                    chk("small_last_y", s_win_y, 3);
                end
            end
            xf = s_pix_valid && s_pix_ready;
            @(posedge clk);
            if (xf) sidx++;
        end
        @(negedge clk);
        s_pix_valid = 0;
        chk("small_done_seen", sdone, 1);
        chk("small_window_count", nw, 9);
        chk("small_busy_after", s_busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_win_valid", win_valid, 0);
        chk("reset_pix_ready", pix_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_win_pix", win_pix, 0);
        chk("reset_frame_done", frame_done, 0);
        rst_n = 1;
        run_small();
        run_frame(75, 75, 0, -1);
        run_frame(100, 100, 1, -1);
        run_frame(80, 80, 0, 50 * W + 17);
        run_frame(100, 100, 0, -1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 Parameter IMG_W, default 120, image width in pixels.
REQ-002 Parameter IMG_H, default 120, image height in pixels.
REQ-003 Parameter PIX_W, default 3, pixel width (bit 2 R, bit 1 G, bit 0 B).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse; begins a frame when idle.
REQ-007 pix_valid  in  1  upstream pixel present on pix_din.
REQ-008 pix_din  in  PIX_W  raster-order pixel: row 0 first, left to right.
REQ-009 pix_ready  out  1  block accepts pix_din this cycle.
REQ-010 win_valid  out  1  3x3 window present on win_pix/win_x/win_y.
REQ-011 win_ready  in  1  downstream convolution datapath consumes window.
REQ-012 win_pix  out  9*PIX_W  window; slice k = pixel (win_x-1+k%3, win_y-1+k/3), k=0..8.
REQ-013 win_x, win_y  out  8 each  window centre coordinates.
REQ-014 busy  out  1  high from accepted start until frame_done.
REQ-015 frame_done  out  1  one-cycle pulse on last window handshake.

Function
REQ-016 FSM states IDLE, STREAM. IDLE->STREAM on start; STREAM->IDLE on last-window handshake.
REQ-017 start while in STREAM shall be ignored.
REQ-018 pix_ready = (state==STREAM) && (!win_valid || win_ready) && (input not complete); pixels offered in IDLE are not consumed.
REQ-019 Input transfer on pix_valid && pix_ready. Column counter wraps IMG_W-1 -> 0 and increments the row counter.
REQ-020 Two line buffers of IMG_W x PIX_W hold rows y-1 and y-2; a 3x3 shift register of columns is fed by {line2[x], line1[x], pix_din} on each transfer.
REQ-021 Windows are emitted only for interior centres, x in 1..IMG_W-2 and y in 1..IMG_H-2: (IMG_W-2)*(IMG_H-2) windows per frame (13924 at the defaults).
REQ-022 The window for centre (x,y) shall be registered, with win_valid=1, in the cycle after the transfer of pixel (x+1,y+1); latency is 1 cycle.
REQ-023 win_valid && !win_ready: win_pix, win_x, win_y and win_valid shall hold stable, and input stalls.
REQ-024 Window handshake: win_valid && win_ready. If a new window is produced in the same cycle, the output is reloaded with no bubble.
REQ-025 Row wrap: border columns shall not produce windows, and no window mixes pixels from different rows.
REQ-026 frame_done pulses in the handshake cycle of window (IMG_W-2, IMG_H-2); busy falls in the same cycle.
REQ-027 Line-buffer contents are not reset. Stale contents shall never appear in an emitted window.

Reset
REQ-028 rst_n low: state=IDLE, counters=0, win_valid=0, win_pix=0, win_x=0, win_y=0, busy=0, frame_done=0, pix_ready=0.
REQ-029 Reset mid-frame aborts the frame immediately. The next start begins at pixel (0,0).

Configuration
REQ-030 Macro CONV_WIN_STALL_CNT_EN defined: add output win_stall_cnt (16-bit) that counts cycles with win_valid && !win_ready, saturates at 65535, clears on accepted start and on reset.
REQ-031 Macro CONV_WIN_STALL_CNT_EN undefined: the port and the counter are absent, and all other behaviour is identical.

Structure
REQ-032 Shared package conv_pkg holds the IMG_W/IMG_H/PIX_W defaults, the FSM state typedef and the window-slice index constants.
REQ-033 One sub-module, conv_line_buf (single-port-per-cycle, IMG_W-deep delay RAM), instantiated twice.

Verification
REQ-034 IMG_W=IMG_H=5, pixel value = (x+y)%8, pix_valid and win_ready always 1 -> 9 windows. First window centre (1,1), win_pix slices 0..8 = 0,1,2,1,2,3,2,3,4. frame_done with centre (3,3).
REQ-035 Defaults, win_ready held 0 for 20 cycles after the first window -> pix_ready=0, win_* stable, win_stall_cnt=20 (macro on).
REQ-036 Defaults, random pix_valid/win_ready -> window count 13924 and every window matches a reference model.
REQ-037 rst_n low during row 50 -> all outputs at reset values. A new start then yields a first window of (1,1) built only from the new frame's data.
REQ-038 start pulsed during STREAM -> no effect on counters or output order. pix_valid in IDLE -> pix_ready=0, no window.
